psram_access_arbiter: RTL and testbench

//  Shares the single PSRAM memory port between two requesters: the display (VGA line fetch) and the MCU bus (host rd/wr).

---
 rtl/psram_access_arbiter.sv | 176 +++++++++++++++++
 tb/tb_psram_access_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_access_arbiter.sv
// Two-requester arbiter for a single PSRAM controller port: display reads take priority, with a
// bounded burst so the MCU is never starved, and a watchdog that aborts accesses that never finish.
module psram_access_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 23,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DISPLAY_BURST = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                  system_clock,
  input  logic                  reset,
  // display requester (read only)
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  disp_ack,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  // MCU requester
  input  logic                  mcu_req,
  input  logic                  mcu_we,
  input  logic [ADDR_WIDTH-1:0] mcu_addr,
  input  logic [DATA_WIDTH-1:0] mcu_wdata,
  output logic                  mcu_ack,
  output logic [DATA_WIDTH-1:0] mcu_rdata,
  // psram controller side
  input  logic                  mem_ready,
  output logic                  mem_request,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_done,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  timeout_error
);

  localparam int unsigned BurstW = $clog2(DISPLAY_BURST + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(DISPLAY_BURST);
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StRespond
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_mcu_q, grant_mcu_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] disp_rdata_q, disp_rdata_d;
  logic [DATA_WIDTH-1:0] mcu_rdata_q, mcu_rdata_d;
  logic [BurstW-1:0]     burst_q, burst_d;
  logic [7:0]            wait_q, wait_d;
  logic                  timeout_q, timeout_d;

  logic                  pick_mcu;
  logic                  wait_expired;
  logic                  capture;
  logic [DATA_WIDTH-1:0] capture_data;

  // Display wins ties until it has taken DISPLAY_BURST grants in a row against a waiting MCU.
  assign pick_mcu     = mcu_req && (!disp_req || (burst_q == BurstMax));
  assign wait_expired = (wait_q == WaitLast);

  always_comb begin
    state_d       = state_q;
    grant_mcu_d   = grant_mcu_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    burst_d       = burst_q;
    wait_d        = wait_q;
    timeout_d     = timeout_q;
    capture       = 1'b0;
    capture_data  = '0;

    unique case (state_q)
      StIdle: begin
        if (disp_req || mcu_req) begin
          state_d = StIssue;
          if (pick_mcu) begin
            grant_mcu_d   = 1'b1;
            mem_write_d   = mcu_we;
            mem_address_d = mcu_addr;
            mem_wdata_d   = mcu_wdata;
            burst_d       = '0;
          end else begin
            grant_mcu_d   = 1'b0;
            mem_write_d   = 1'b0;
            mem_address_d = disp_addr;
            mem_wdata_d   = '0;
            if (mcu_req && (burst_q != BurstMax)) begin
              burst_d = burst_q + BurstW'(1);
            end
          end
        end
      end
      StIssue: begin
        wait_d = '0;
        if (mem_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_done) begin
          capture      = 1'b1;
          capture_data = mem_rdata;
          state_d      = StRespond;
        end else if (wait_expired) begin
          // Aborted reads return zero so stale data is never mistaken for a result.
          capture      = 1'b1;
          capture_data = '0;
          timeout_d    = 1'b1;
          state_d      = StRespond;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StRespond: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    disp_rdata_d = disp_rdata_q;
    mcu_rdata_d  = mcu_rdata_q;
    if (capture && !mem_write_q) begin
      if (grant_mcu_q) begin
        mcu_rdata_d = capture_data;
      end else begin
        disp_rdata_d = capture_data;
      end
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_mcu_q   <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      disp_rdata_q  <= '0;
      mcu_rdata_q   <= '0;
      burst_q       <= '0;
      wait_q        <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_mcu_q   <= grant_mcu_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      disp_rdata_q  <= disp_rdata_d;
      mcu_rdata_q   <= mcu_rdata_d;
      burst_q       <= burst_d;
      wait_q        <= wait_d;
      timeout_q     <= timeout_d;
    end
  end

  assign mem_request   = (state_q == StIssue) && mem_ready;
  assign disp_ack      = (state_q == StRespond) && !grant_mcu_q;
  assign mcu_ack       = (state_q == StRespond) && grant_mcu_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_wdata     = mem_wdata_q;
  assign disp_rdata    = disp_rdata_q;
  assign mcu_rdata     = mcu_rdata_q;
  assign timeout_error = timeout_q;

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Scoreboard bench for psram_access_arbiter: a behavioural psram controller checks each command
// strobe, and a monitor checks every ack against the queue of expected responses.
module tb_psram_access_arbiter;

  logic        clk;
  logic        reset;
  logic        disp_req;
  logic [22:0] disp_addr;
  logic        disp_ack;
  logic [7:0]  disp_rdata;
  logic        mcu_req;
  logic        mcu_we;
  logic [22:0] mcu_addr;
  logic [7:0]  mcu_wdata;
  logic        mcu_ack;
  logic [7:0]  mcu_rdata;
  logic        mem_ready;
  logic        mem_request;
  logic        mem_write;
  logic [22:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_done;
  logic [7:0]  mem_rdata;
  logic        timeout_error;

  psram_access_arbiter dut (
    .system_clock (clk),
    .reset        (reset),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_ack     (disp_ack),
    .disp_rdata   (disp_rdata),
    .mcu_req      (mcu_req),
    .mcu_we       (mcu_we),
    .mcu_addr     (mcu_addr),
    .mcu_wdata    (mcu_wdata),
    .mcu_ack      (mcu_ack),
    .mcu_rdata    (mcu_rdata),
    .mem_ready    (mem_ready),
    .mem_request  (mem_request),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_done     (mem_done),
    .mem_rdata    (mem_rdata),
    .timeout_error(timeout_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [22:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  typedef struct {
    logic       mcu;
    logic       chk;
    logic [7:0] rdata;
    logic       tmo;
  } ack_t;

  cmd_t cmd_q[$];
  ack_t ack_q[$];

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  // psram model knobs, set by the stimulus before each request
  logic       hang;
  int         done_delay;
  logic [7:0] rd_value;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic mcu, input logic we, input logic [22:0] addr,
                      input logic [7:0] wdata, input logic chk, input logic [7:0] rdata,
                      input logic tmo);
    cmd_t c;
    ack_t a;
    c.we = we;
    c.addr = addr;
    c.wdata = wdata;
    a.mcu = mcu;
    a.chk = chk;
    a.rdata = rdata;
    a.tmo = tmo;
    cmd_q.push_back(c);
    ack_q.push_back(a);
  endtask

  task automatic wait_acks(input int n, input int budget, input string name, output int cycles);
    int got;
    got = 0;
    cycles = 0;
    while (got < n && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (disp_ack || mcu_ack) got++;
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d acks expected %0d within %0d cycles", name, got, n, budget);
    end
  endtask

  // behavioural psram controller: one command in flight
  initial begin
    cmd_t c;
    mem_done = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_request) begin
        strobes++;
        if (cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got mem_request expected none at %0t", $time);
        end else begin
          c = cmd_q.pop_front();
          check("cmd_write", 32'(mem_write), 32'(c.we));
          check("cmd_addr", 32'(mem_address), 32'(c.addr));
          if (c.we) check("cmd_wdata", 32'(mem_wdata), 32'(c.wdata));
        end
        if (!hang) begin
          repeat (done_delay) @(posedge clk);
          #1;
          mem_done = 1'b1;
          mem_rdata = rd_value;
          @(posedge clk);
          #1;
          mem_done = 1'b0;
          mem_rdata = 8'h00;
        end
      end
    end
  end

  // ack monitor
  initial begin
    ack_t a;
    forever begin
      @(negedge clk);
      if (disp_ack || mcu_ack) begin
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got disp=%0b mcu=%0b expected none at %0t",
                   disp_ack, mcu_ack, $time);
        end else begin
          a = ack_q.pop_front();
          check("ack_exclusive", 32'(disp_ack & mcu_ack), 32'd0);
          check("ack_source", 32'(mcu_ack), 32'(a.mcu));
          if (a.chk) check("ack_rdata", 32'(a.mcu ? mcu_rdata : disp_rdata), 32'(a.rdata));
          check("ack_timeout_flag", 32'(timeout_error), 32'(a.tmo));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc;
    int s0;
    reset = 1'b1;
    disp_req = 1'b0;
    disp_addr = '0;
    mcu_req = 1'b0;
    mcu_we = 1'b0;
    mcu_addr = '0;
    mcu_wdata = '0;
    mem_ready = 1'b1;
    hang = 1'b0;
    done_delay = 1;
    rd_value = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_disp_ack", 32'(disp_ack), 32'd0);
    check("rst_mcu_ack", 32'(mcu_ack), 32'd0);
    check("rst_mem_request", 32'(mem_request), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rdata", 32'({disp_rdata, mcu_rdata}), 32'd0);
    check("rst_timeout_error", 32'(timeout_error), 32'd0);

    // 1: MCU write, done three cycles after the strobe
    repeat (2) @(posedge clk);
    #1;
    mcu_we = 1'b1;
    mcu_addr = 23'h000123;
    mcu_wdata = 8'hA5;
    done_delay = 3;
    push(1'b1, 1'b1, 23'h000123, 8'hA5, 1'b0, 8'h00, 1'b0);
    mcu_req = 1'b1;
    wait_acks(1, 50, "t1_ack_wait", cyc);
    mcu_req = 1'b0;
    check("t1_latency", 32'(cyc), 32'd5);
    check("t1_mem_write_held", 32'(mem_write), 32'd1);
    check("t1_mem_address_held", 32'(mem_address), 32'h000123);

    // 2: display read
    repeat (2) @(posedge clk);
    #1;
    disp_addr = 23'h000200;
    done_delay = 2;
    rd_value = 8'h3C;
    push(1'b0, 1'b0, 23'h000200, 8'h00, 1'b1, 8'h3C, 1'b0);
    disp_req = 1'b1;
    wait_acks(1, 50, "t2_ack_wait", cyc);
    disp_req = 1'b0;
    check("t2_latency", 32'(cyc), 32'd4);
    check("t2_disp_rdata", 32'(disp_rdata), 32'h3C);

    // 3: both held high; display bursts of four then one MCU write
    repeat (2) @(posedge clk);
    #1;
    disp_addr = 23'h000300;
    mcu_we = 1'b1;
    mcu_addr = 23'h000301;
    mcu_wdata = 8'h99;
    done_delay = 1;
    rd_value = 8'h11;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) push(1'b1, 1'b1, 23'h000301, 8'h99, 1'b0, 8'h00, 1'b0);
      else push(1'b0, 1'b0, 23'h000300, 8'h00, 1'b1, 8'h11, 1'b0);
    end
    disp_req = 1'b1;
    mcu_req = 1'b1;
    wait_acks(10, 200, "t3_ack_wait", cyc);
    disp_req = 1'b0;
    mcu_req = 1'b0;

    // 4: mem_ready low for ten cycles while the MCU read sits in ISSUE
    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    mcu_we = 1'b0;
    mcu_addr = 23'h000400;
    done_delay = 2;
    rd_value = 8'h5A;
    s0 = strobes;
    push(1'b1, 1'b0, 23'h000400, 8'h00, 1'b1, 8'h5A, 1'b0);
    mcu_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("t4_request_withheld", 32'(mem_request), 32'd0);
    end
    mem_ready = 1'b1;
    wait_acks(1, 50, "t4_ack_wait", cyc);
    mcu_req = 1'b0;
    check("t4_single_strobe", 32'(strobes - s0), 32'd1);
    check("t4_mcu_rdata", 32'(mcu_rdata), 32'h5A);

    // 5: mem_done never arrives; watchdog aborts, then a normal read still works
    repeat (2) @(posedge clk);
    #1;
    hang = 1'b1;
    disp_addr = 23'h000500;
    push(1'b0, 1'b0, 23'h000500, 8'h00, 1'b1, 8'h00, 1'b1);
    disp_req = 1'b1;
    wait_acks(1, 400, "t5_ack_wait", cyc);
    disp_req = 1'b0;
    check("t5_timeout_latency", 32'(cyc), 32'd257);
    check("t5_timeout_error", 32'(timeout_error), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    hang = 1'b0;
    done_delay = 1;
    rd_value = 8'h77;
    mcu_addr = 23'h000501;
    push(1'b1, 1'b0, 23'h000501, 8'h00, 1'b1, 8'h77, 1'b1);
    mcu_req = 1'b1;
    wait_acks(1, 50, "t5_recover_wait", cyc);
    mcu_req = 1'b0;
    check("t5_recover_latency", 32'(cyc), 32'd3);

    // 6: reset while waiting on the controller
    repeat (2) @(posedge clk);
    #1;
    hang = 1'b1;
    disp_addr = 23'h000600;
    cmd_q.push_back('{we: 1'b0, addr: 23'h000600, wdata: 8'h00});
    disp_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    disp_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_mem_request", 32'(mem_request), 32'd0);
    check("t6_disp_ack", 32'(disp_ack), 32'd0);
    check("t6_timeout_cleared", 32'(timeout_error), 32'd0);
    check("t6_mem_address", 32'(mem_address), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    hang = 1'b0;
    done_delay = 2;
    rd_value = 8'hC3;
    disp_addr = 23'h000601;
    push(1'b0, 1'b0, 23'h000601, 8'h00, 1'b1, 8'hC3, 1'b0);
    disp_req = 1'b1;
    wait_acks(1, 50, "t6_recover_wait", cyc);
    disp_req = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
    check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
